// File: rtl/board_pkg.sv
// board_pkg: shared tile type, board defaults and FSM state encoding for the board update engine.
package board_pkg;
    localparam int COLS_DEF   = 32;
    localparam int ROWS_DEF   = 24;
    localparam int TILE_W_DEF = 4;
    typedef logic [TILE_W_DEF-1:0] tile_t;
    localparam tile_t TILE_EMPTY = '0;
    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, COMMIT} state_t;
endpackage

// File: rtl/board_update_engine_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; search starts after the last granted requester and wraps.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] ptr_q;
    logic          found;
    int            c;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_q) + k;
            c = c >= N ? c - N : c;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                index    = IW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= '0;
        else if (advance)
            ptr_q <= int'(index) == N - 1 ? '0 : index + 1'b1;
    end
endmodule

// File: rtl/board_update_engine.sv
// board_update_engine: arbitrates sprite moves and erases/redraws them in the board RAM.
// Optional BOARD_BOUNDS_CHECK_EN rejects targets outside the board with an err pulse.
module board_update_engine import board_pkg::*; #(
    parameter int N_SPR    = 4,
    parameter int COLS     = COLS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int ADDR_W   = 10,
    parameter int TILE_W   = TILE_W_DEF,
    parameter int SPR_TILE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_en,
    input  logic                    start,
    input  logic [N_SPR*ADDR_W-1:0] home_loc,
    input  logic [N_SPR-1:0]        req_valid,
    input  logic [N_SPR*ADDR_W-1:0] req_loc,
    output logic [N_SPR-1:0]        req_ready,
    output logic [N_SPR*ADDR_W-1:0] loc,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [TILE_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    err
);
    localparam int IW = N_SPR > 1 ? $clog2(N_SPR) : 1;

    state_t            state_q, state_d;
    logic [IW-1:0]     g_q, gidx;
    logic [N_SPR-1:0]  grant;
    logic [ADDR_W-1:0] tgt_q, sel_loc;
    logic [ADDR_W-1:0] loc_q [N_SPR];
    logic              post_rst_q, accept, oob, move;

    rr_arbiter #(.N(N_SPR)) u_arb (
        .clk     (clk),
        .reset   (reset | start),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .index   (gidx)
    );

    // Requests are ignored in the cycle after reset so requesters see a quiet startup.
    assign accept  = state_q == IDLE && step_en && |req_valid && !start && !reset && !post_rst_q;
    assign sel_loc = req_loc[gidx*ADDR_W +: ADDR_W];

`ifdef BOARD_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(COLS*ROWS);
    assign oob = {1'b0, sel_loc} >= CELLS;
    assign err = accept && oob;
`else
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    assign move      = accept && !oob && sel_loc != loc_q[gidx];
    assign req_ready = accept ? grant : '0;
    assign busy      = state_q != IDLE;

    always_comb begin
        state_d = move ? CLEAR : state_q == CLEAR ? DRAW : state_q == DRAW ? COMMIT : IDLE;
        wr_en   = state_q == CLEAR || state_q == DRAW;
        wr_addr = state_q == CLEAR ? loc_q[g_q] : tgt_q;
        wr_data = state_q == CLEAR ? TILE_W'(TILE_EMPTY) : TILE_W'(SPR_TILE) + TILE_W'(g_q);
    end

    always_ff @(posedge clk) begin
        post_rst_q <= reset;
        if (reset || start) begin
            state_q <= IDLE;
            for (int i = 0; i < N_SPR; i++)
                loc_q[i] <= home_loc[i*ADDR_W +: ADDR_W];
        end else begin
            state_q <= state_d;
            if (move) begin
                g_q   <= gidx;
                tgt_q <= sel_loc;
            end
            if (state_q == COMMIT)
                loc_q[g_q] <= tgt_q;
        end
    end

    for (genvar i = 0; i < N_SPR; i++) begin : g_loc
        assign loc[i*ADDR_W +: ADDR_W] = loc_q[i];
    end
endmodule

// File: tb/tb_board_update_engine.sv
// tb_board_update_engine: transaction-level model of sprite moves checked every cycle, plus directed scenarios.
module tb_board_update_engine;
    logic        clk = 0, reset = 1, step_en = 1, start = 0;
    logic [39:0] home_loc = {10'd300, 10'd200, 10'd100, 10'd495};
    logic [3:0]  req_valid = 0;
    logic [39:0] req_loc = 0;
    logic [3:0]  req_ready;
    logic [39:0] loc;
    logic        wr_en, busy, err;
    logic [9:0]  wr_addr;
    logic [3:0]  wr_data;

`ifdef BOARD_BOUNDS_CHECK_EN
    localparam bit BCHK = 1;
`else
    localparam bit BCHK = 0;
`endif

    board_update_engine dut (
        .clk(clk), .reset(reset), .step_en(step_en), .start(start), .home_loc(home_loc),
        .req_valid(req_valid), .req_loc(req_loc), .req_ready(req_ready), .loc(loc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, nerr = 0;
    logic [13:0] wlog[$];
    int glog[$], gcyc[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: move progress counts cycles since acceptance (1 = erase, 2 = draw, 3 = commit).
    int  mloc[4], phase = 0, mg = 0, mtgt = 0, mptr = 0;
    bit  mvalid = 0, post_rst = 0;

    function automatic int exp_g();
        if (phase != 0 || !step_en || start || reset || post_rst) return -1;
        for (int k = 0; k < 4; k++)
            if (req_valid[(mptr + k) % 4]) return (mptr + k) % 4;
        return -1;
    endfunction

    function automatic int tgt_of(int g);
        return int'(req_loc[g*10 +: 10]);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        post_rst <= reset;
        if (reset || start) begin
            mvalid <= 1;
            phase  <= 0;
            mptr   <= 0;
            for (int i = 0; i < 4; i++) mloc[i] <= int'(home_loc[i*10 +: 10]);
        end else if (exp_g() >= 0) begin
            mptr <= (exp_g() + 1) % 4;
            if (!(BCHK && tgt_of(exp_g()) >= 768) && tgt_of(exp_g()) != mloc[exp_g()]) begin
                phase <= 1;
                mg    <= exp_g();
                mtgt  <= tgt_of(exp_g());
            end
        end else if (phase == 3) begin
            mloc[mg] <= mtgt;
            phase    <= 0;
        end else if (phase != 0) begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("req_ready", 32'(req_ready), exp_g() >= 0 ? 32'(1) << exp_g() : 0);
            chk("err", 32'(err), 32'(exp_g() >= 0 && BCHK && tgt_of(exp_g()) >= 768));
            chk("busy", 32'(busy), 32'(phase != 0));
            chk("wr_en", 32'(wr_en), 32'(phase == 1 || phase == 2));
            if (phase == 1) begin
                chk("clr_addr", 32'(wr_addr), mloc[mg]);
                chk("clr_data", 32'(wr_data), 0);
            end
            if (phase == 2) begin
                chk("drw_addr", 32'(wr_addr), mtgt);
                chk("drw_data", 32'(wr_data), 3 + mg);
            end
            for (int i = 0; i < 4; i++) chk("loc", 32'(loc[i*10 +: 10]), mloc[i]);
            if (wr_en) wlog.push_back({wr_addr, wr_data});
            if (err) nerr++;
            for (int i = 0; i < 4; i++)
                if (req_ready[i]) begin
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                end
        end
    end

    task automatic clear_logs();
        wlog.delete();
        glog.delete();
        gcyc.delete();
        nerr = 0;
    endtask

    task automatic do_reset();
        @(posedge clk) #1 reset = 1;
        @(posedge clk) #1;
        @(posedge clk) #1 reset = 0;
    endtask

    task automatic do_req(int ch, logic [9:0] tgt);
        bit got = 0;
        req_loc[ch*10 +: 10] = tgt;
        req_valid[ch] = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_ready[ch];
        end
        chk("req_timeout", 32'(got), 1);
        @(posedge clk) #1 req_valid[ch] = 0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r;
        do_reset();
        @(negedge clk);
        chk("rst_loc0", 32'(loc[9:0]), 495);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_en", 32'(wr_en), 0);

        // Single move 495 -> 496 on channel 0
        clear_logs();
        do_req(0, 10'd496);
        idle(5);
        chk("m0_nwr", wlog.size(), 2);
        chk("m0_w0", 32'(wlog[0]), {10'd495, 4'd0});
        chk("m0_w1", 32'(wlog[1]), {10'd496, 4'd3});
        chk("m0_loc", 32'(loc[9:0]), 496);

        // All four channels at once after reset
        do_reset();
        clear_logs();
        req_loc = {10'd301, 10'd201, 10'd101, 10'd496};
        req_valid = 4'b1111;
        for (int n = 0; n < 40 && req_valid != 0; n++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk) #1 req_valid &= ~r;
        end
        idle(5);
        chk("all_ngr", glog.size(), 4);
        chk("all_nwr", wlog.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk("all_order", glog[i], i);
            chk("all_tile", 32'(wlog[2*i+1][3:0]), 3 + i);
            if (i > 0) chk("all_gap", gcyc[i] - gcyc[i-1], 4);
        end
        chk("all_loc3", 32'(loc[39:30]), 301);

        // Same-block request on channel 1
        clear_logs();
        do_req(1, 10'd101);
        idle(4);
        chk("same_ngr", glog.size(), 1);
        chk("same_nwr", wlog.size(), 0);

        // start during DRAW aborts the move
        do_reset();
        clear_logs();
        do_req(0, 10'd496);
        @(posedge clk) #1;
        start = 1;
        req_loc[19:10] = 10'd150;
        req_valid[1] = 1;
        @(posedge clk) #1;
        start = 0;
        req_valid[1] = 0;
        @(negedge clk);
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_loc0", 32'(loc[9:0]), 495);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ngr", glog.size(), 1);
        idle(3);
        chk("abort_loc0b", 32'(loc[9:0]), 495);

        // step_en low blocks everything
        clear_logs();
        step_en = 0;
        req_valid = 4'b1111;
        idle(20);
        chk("noen_ngr", glog.size(), 0);
        chk("noen_nwr", wlog.size(), 0);
        req_valid = 0;
        step_en = 1;
        idle(1);

        // Out-of-range target on channel 2
        clear_logs();
        do_req(2, 10'd800);
        idle(5);
        if (BCHK) begin
            chk("oob_err", nerr, 1);
            chk("oob_nwr", wlog.size(), 0);
            chk("oob_loc2", 32'(loc[29:20]), 200);
        end else begin
            chk("oob_err", nerr, 0);
            chk("oob_nwr", wlog.size(), 2);
            chk("oob_w0", 32'(wlog[0]), {10'd200, 4'd0});
            chk("oob_w1", 32'(wlog[1]), {10'd800, 4'd5});
            chk("oob_loc2", 32'(loc[29:20]), 800);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/board_update_engine.md
BOARD_UPDATE_ENGINE -- requirements
Module: board_update_engine

Interface
REQ-001 Parameter N_SPR, default 4, number of sprite channels (Pac-Man plus ghosts).
REQ-002 Parameter COLS, default 32, board width in blocks.
REQ-003 Parameter ROWS, default 24, board height in blocks.
REQ-004 Parameter ADDR_W, default 10, block address width; must satisfy 2^ADDR_W >= COLS*ROWS.
REQ-005 Parameter TILE_W, default 4, block-type code width.
REQ-006 Parameter SPR_TILE, default 3, tile code for channel 0; channel i draws SPR_TILE+i.
REQ-007 clk  in  1  system clock; all logic on posedge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 step_en  in  1  game-tick enable; new moves are accepted only while high.
REQ-010 start  in  1  soft restart; returns every sprite to its home block.
REQ-011 home_loc  in  N_SPR*ADDR_W  per-channel home block address.
REQ-012 req_valid  in  N_SPR  per-channel move request.
REQ-013 req_loc  in  N_SPR*ADDR_W  per-channel target block address.
REQ-014 req_ready  out  N_SPR  one-cycle accept pulse per channel.
REQ-015 loc  out  N_SPR*ADDR_W  committed block address per channel.
REQ-016 wr_en, wr_addr[ADDR_W], wr_data[TILE_W]  out  write port to the board RAM.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.
REQ-018 err  out  1  one-cycle pulse on a rejected request; tied 0 when the bounds check is compiled out.

Function
REQ-019 FSM states: IDLE, CLEAR, DRAW, COMMIT.
REQ-020 Acceptance: in IDLE with step_en=1 and any req_valid=1, the round-robin arbiter grants exactly one channel g; req_ready[g]=1 for that cycle only; g and req_loc[g] are latched.
REQ-021 Arbitration: search starts at the channel after the last granted one and wraps from N_SPR-1 to 0.
REQ-022 IDLE -> CLEAR on acceptance when req_loc[g] != loc[g]; IDLE -> IDLE otherwise (same-block request is acknowledged with no writes).
REQ-023 CLEAR: wr_en=1, wr_addr=loc[g], wr_data=0 (empty tile); next state DRAW.
REQ-024 DRAW: wr_en=1, wr_addr=latched target, wr_data=SPR_TILE+g; next state COMMIT.
REQ-025 COMMIT: wr_en=0; loc[g] takes the latched target at the end of the cycle; next state IDLE.
REQ-026 wr_* outputs decode from the state register (Moore); wr_en=0 in IDLE and COMMIT; wr_addr and wr_data are don't-care while wr_en=0.
REQ-027 Latency: accept at cycle T, clear write at T+1, draw write at T+2, loc update visible at T+4; maximum throughput is one move per 4 cycles.
REQ-028 Requests are neither accepted nor queued while busy=1 or step_en=0; requesters hold req_valid until they see req_ready.
REQ-029 start=1 in any state: loc[i] <= home_loc[i] for every i; FSM -> IDLE; arbiter pointer -> 0; no req_ready that cycle; wr_en=0 from the next cycle on.
REQ-030 start has priority over acceptance and over an in-flight move, and does not redraw home tiles.

Reset
REQ-031 reset=1 forces the same effects as start: FSM=IDLE, loc[i]=home_loc[i], arbiter pointer=0.
REQ-032 During reset and in the cycle after it: wr_en=0, req_ready=0, busy=0, err=0.
REQ-033 reset asserted mid-move aborts the move; loc[g] is not updated.

Configuration
REQ-034 Macro BOARD_BOUNDS_CHECK_EN defined: an accepted request with req_loc >= COLS*ROWS pulses err and req_ready for one cycle, performs no writes, leaves loc unchanged, and the FSM stays in IDLE.
REQ-035 Macro BOARD_BOUNDS_CHECK_EN undefined: no range check is done, an out-of-range request is processed as a normal move, and err is constant 0.

Structure
REQ-036 The shared package board_pkg holds TILE_EMPTY (0), the tile_t typedef, the default COLS/ROWS, and the FSM state enum.
REQ-037 Sub-module rr_arbiter (parameter N; inputs req, advance; outputs one-hot grant and index) implements REQ-021.

Verification
REQ-038 After reset with home_loc[0]=495, loc0=495; req ch0 to 496 with step_en -> req_ready[0] pulse, writes (495,0) then (496,3), loc0=496 at T+4.
REQ-039 All 4 channels request together after reset -> grants in order 0,1,2,3, one every 4 cycles; 8 writes total; draw tiles 3,4,5,6.
REQ-040 ch1 requests loc1 (same block) -> req_ready[1] pulse, wr_en stays 0, busy stays 0.
REQ-041 start asserted during DRAW of a ch0 move from 495 to 496 -> wr_en=0 next cycle, loc0=495, FSM=IDLE, no req_ready in the start cycle.
REQ-042 step_en=0 with req_valid=4'b1111 held for 20 cycles -> no req_ready and no writes.
REQ-043 With BOARD_BOUNDS_CHECK_EN, req ch2 to 800 (>= 768) -> err and req_ready[2] pulse, no writes, loc2 unchanged; without the macro -> writes at addresses loc2 and 800.
